// File: rtl/inst_queue.sv
// inst_queue: dual-in/dual-out circular instruction queue sitting between
// fetch and decode. Presents the two oldest entries first-word-fall-through,
// accepts up to two new entries per cycle and retires up to two per cycle.
module inst_queue #(
   parameter int DEPTH  = 8,
   parameter int INST_W = 32,
   parameter int PC_W   = 32,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              stop,
   input  logic [INST_W-1:0] in1_inst,
   input  logic [PC_W-1:0]   in1_pc,
   input  logic [PC_W-1:0]   in1_npc,
   input  logic              receive_flag1,
   input  logic [INST_W-1:0] in2_inst,
   input  logic [PC_W-1:0]   in2_pc,
   input  logic [PC_W-1:0]   in2_npc,
   input  logic              receive_flag2,
   output logic [INST_W-1:0] out1_inst,
   output logic [PC_W-1:0]   out1_pc,
   output logic [PC_W-1:0]   out1_npc,
   output logic              sendout_flag1,
   input  logic              launch_flag1,
   output logic [INST_W-1:0] out2_inst,
   output logic [PC_W-1:0]   out2_pc,
   output logic [PC_W-1:0]   out2_npc,
   output logic              sendout_flag2,
   input  logic              launch_flag2,
   output logic              instbuf_full,
   output logic [CNT_W-1:0]  count,
   output logic              overflow_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int WID   = CNT_W + 1;

   logic [INST_W-1:0] mem_inst [DEPTH];
   logic [PC_W-1:0]   mem_pc   [DEPTH];
   logic [PC_W-1:0]   mem_npc  [DEPTH];

   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [PTR_W-1:0]  head_plus1;
   logic [PTR_W-1:0]  tail_plus1;
   logic [1:0]        pop;
   logic [1:0]        req;
   logic [1:0]        push;
   logic [WID-1:0]    free;
   logic              drop;
   logic [INST_W-1:0] wr0_inst;
   logic [PC_W-1:0]   wr0_pc;
   logic [PC_W-1:0]   wr0_npc;

   assign head_plus1    = head + PTR_W'(1);
   assign tail_plus1    = tail + PTR_W'(1);
   assign sendout_flag1 = (count != '0);
   assign sendout_flag2 = (count > CNT_W'(1));
   assign instbuf_full  = (WID'(DEPTH) - WID'(count)) < WID'(2);

   // Number of entries decode retires this cycle; lane 2 only retires alongside lane 1.
   always_comb begin
      pop = 2'd0;
      if (!stop) begin
         pop = {1'b0, launch_flag1 & sendout_flag1}
             + {1'b0, launch_flag1 & launch_flag2 & sendout_flag2};
      end
   end

   // Clip the write request to the room left after this cycle's retirements; the younger write is the one lost.
   always_comb begin
      req  = {1'b0, receive_flag1} + {1'b0, receive_flag2};
      free = WID'(DEPTH) - WID'(count) + WID'(pop);
      push = req;
      drop = 1'b0;
      if (WID'(req) > free) begin
         push = free[1:0];
         drop = 1'b1;
      end
   end

   // A lone in2 is compacted into the first free slot so the queue stays gap-free.
   always_comb begin
      wr0_inst = in1_inst;
      wr0_pc   = in1_pc;
      wr0_npc  = in1_npc;
      if (!receive_flag1) begin
         wr0_inst = in2_inst;
         wr0_pc   = in2_pc;
         wr0_npc  = in2_npc;
      end
   end

   // Storage array; contents need no reset because the valid flags mask them.
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (push != 2'd0) begin
            mem_inst[tail] <= wr0_inst;
            mem_pc[tail]   <= wr0_pc;
            mem_npc[tail]  <= wr0_npc;
         end
         if (push == 2'd2) begin
            mem_inst[tail_plus1] <= in2_inst;
            mem_pc[tail_plus1]   <= in2_pc;
            mem_npc[tail_plus1]  <= in2_npc;
         end
      end
   end

   // Pointer and occupancy update; flush wins over any push or pop, but keeps the sticky overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         overflow_err <= 1'b0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(pop);
         tail  <= tail + PTR_W'(push);
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (drop) overflow_err <= 1'b1;
      end
   end

   // First-word-fall-through outputs, zeroed on any lane that holds no valid entry.
   always_comb begin
      out1_inst = '0;
      out1_pc   = '0;
      out1_npc  = '0;
      out2_inst = '0;
      out2_pc   = '0;
      out2_npc  = '0;
      if (sendout_flag1) begin
         out1_inst = mem_inst[head];
         out1_pc   = mem_pc[head];
         out1_npc  = mem_npc[head];
      end
      if (sendout_flag2) begin
         out2_inst = mem_inst[head_plus1];
         out2_pc   = mem_pc[head_plus1];
         out2_npc  = mem_npc[head_plus1];
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed scenarios plus a randomized run of inst_queue,
// checked against a queue-based model of the instruction buffer.
module tb_inst_queue;

   localparam int DEPTH  = 8;
   localparam int INST_W = 32;
   localparam int PC_W   = 32;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              stop;
   logic [INST_W-1:0] in1_inst, in2_inst, out1_inst, out2_inst;
   logic [PC_W-1:0]   in1_pc, in1_npc, in2_pc, in2_npc;
   logic [PC_W-1:0]   out1_pc, out1_npc, out2_pc, out2_npc;
   logic              receive_flag1, receive_flag2;
   logic              sendout_flag1, sendout_flag2;
   logic              launch_flag1, launch_flag2;
   logic              instbuf_full;
   logic [CNT_W-1:0]  count;
   logic              overflow_err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pc;
      logic [PC_W-1:0]   npc;
   } entry_t;

   entry_t q[$];
   logic   model_ovf = 1'b0;

   inst_queue #(.DEPTH(DEPTH), .INST_W(INST_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stop(stop),
      .in1_inst(in1_inst), .in1_pc(in1_pc), .in1_npc(in1_npc), .receive_flag1(receive_flag1),
      .in2_inst(in2_inst), .in2_pc(in2_pc), .in2_npc(in2_npc), .receive_flag2(receive_flag2),
      .out1_inst(out1_inst), .out1_pc(out1_pc), .out1_npc(out1_npc), .sendout_flag1(sendout_flag1),
      .launch_flag1(launch_flag1),
      .out2_inst(out2_inst), .out2_pc(out2_pc), .out2_npc(out2_npc), .sendout_flag2(sendout_flag2),
      .launch_flag2(launch_flag2),
      .instbuf_full(instbuf_full), .count(count), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic idle();
      flush = 1'b0; stop = 1'b0;
      receive_flag1 = 1'b0; receive_flag2 = 1'b0;
      launch_flag1 = 1'b0; launch_flag2 = 1'b0;
   endtask

   task automatic set_in(input bit r1, input logic [PC_W-1:0] p1,
                         input bit r2, input logic [PC_W-1:0] p2);
      receive_flag1 = r1; in1_pc = p1; in1_npc = p1 + 4; in1_inst = INST_W'(p1 * 3 + 1);
      receive_flag2 = r2; in2_pc = p2; in2_npc = p2 + 4; in2_inst = INST_W'(p2 * 3 + 1);
   endtask

   task automatic set_launch(input bit l1, input bit l2);
      launch_flag1 = l1; launch_flag2 = l2;
   endtask

   // Model step: apply this cycle's inputs to the reference queue, then clock the DUT.
   task automatic advance();
      entry_t e;
      int npop;
      if (flush) begin
         q.delete();
      end else begin
         npop = 0;
         if (!stop && launch_flag1 && q.size() >= 1)
            npop = (launch_flag2 && q.size() >= 2) ? 2 : 1;
         repeat (npop) q.delete(0);
         if (receive_flag1) begin
            e.inst = in1_inst; e.pc = in1_pc; e.npc = in1_npc;
            if (q.size() < DEPTH) q.push_back(e); else model_ovf = 1'b1;
         end
         if (receive_flag2) begin
            e.inst = in2_inst; e.pc = in2_pc; e.npc = in2_npc;
            if (q.size() < DEPTH) q.push_back(e); else model_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_quiet();
      idle();
      rst = 1'b0;
      q.delete();
      model_ovf = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      set_in(1'b0, '0, 1'b0, '0);
      rst = 1'b0;
      #2;
      n_checks++; if (count !== CNT_W'(0)) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
      n_checks++; if (sendout_flag1 !== 1'b0 || sendout_flag2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sendout: got %b%b expected 00", sendout_flag1, sendout_flag2); end
      n_checks++; if (instbuf_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %b expected 0", instbuf_full); end
      n_checks++; if (out1_pc !== '0) begin n_fail++; $display("[TB] FAIL reset_out1_pc: got %0h expected 0", out1_pc); end
      n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow_err); end
      q.delete();
      model_ovf = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++; if (count !== CNT_W'(0) || sendout_flag1 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_release: got count %0d flag1 %b expected 0 0", count, sendout_flag1); end
   endtask

   task automatic test_push_pairs();
      set_in(1'b1, 32'h00, 1'b1, 32'h04);
      advance();
      n_checks++; if (count !== CNT_W'(2)) begin n_fail++; $display("[TB] FAIL push_count2: got %0d expected 2", count); end
      n_checks++; if (out1_pc !== 32'h00 || out2_pc !== 32'h04) begin n_fail++; $display("[TB] FAIL push_pcs1: got %0h/%0h expected 0/4", out1_pc, out2_pc); end
      n_checks++; if (sendout_flag1 !== 1'b1 || sendout_flag2 !== 1'b1) begin n_fail++; $display("[TB] FAIL push_flags: got %b%b expected 11", sendout_flag1, sendout_flag2); end
      set_in(1'b1, 32'h08, 1'b1, 32'h0C);
      advance();
      n_checks++; if (count !== CNT_W'(4)) begin n_fail++; $display("[TB] FAIL push_count4: got %0d expected 4", count); end
      n_checks++; if (out1_pc !== 32'h00 || out2_pc !== 32'h04) begin n_fail++; $display("[TB] FAIL push_pcs2: got %0h/%0h expected 0/4", out1_pc, out2_pc); end
      n_checks++; if (out1_npc !== 32'h04 || out1_inst !== 32'h1) begin n_fail++; $display("[TB] FAIL push_fields: got npc %0h inst %0h expected 4 1", out1_npc, out1_inst); end
   endtask

   task automatic test_pop_while_push();
      set_launch(1'b1, 1'b1);
      set_in(1'b1, 32'h10, 1'b1, 32'h14);
      advance();
      n_checks++; if (count !== CNT_W'(4)) begin n_fail++; $display("[TB] FAIL poppush_count: got %0d expected 4", count); end
      n_checks++; if (out1_pc !== 32'h08 || out2_pc !== 32'h0C) begin n_fail++; $display("[TB] FAIL poppush_pcs: got %0h/%0h expected 8/c", out1_pc, out2_pc); end
      idle();
   endtask

   task automatic test_fill_wrap();
      logic [PC_W-1:0] exp_pc [7];
      reset_quiet();
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, PC_W'(32'h100 + 8 * i), 1'b1, PC_W'(32'h104 + 8 * i));
         advance();
      end
      idle();
      n_checks++; if (count !== CNT_W'(8) || instbuf_full !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_full: got count %0d full %b expected 8 1", count, instbuf_full); end
      set_launch(1'b1, 1'b0);
      advance();
      n_checks++; if (count !== CNT_W'(7) || instbuf_full !== 1'b1) begin n_fail++; $display("[TB] FAIL fill_pop1: got count %0d full %b expected 7 1", count, instbuf_full); end
      n_checks++; if (out1_pc !== 32'h104) begin n_fail++; $display("[TB] FAIL fill_pop1_pc: got %0h expected 104", out1_pc); end
      set_launch(1'b1, 1'b1);
      advance();
      n_checks++; if (count !== CNT_W'(5) || instbuf_full !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_pop2: got count %0d full %b expected 5 0", count, instbuf_full); end
      set_launch(1'b0, 1'b0);
      set_in(1'b1, 32'h120, 1'b1, 32'h124);
      advance();
      idle();
      n_checks++; if (count !== CNT_W'(7)) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d expected 7", count); end
      for (int i = 0; i < 7; i++) exp_pc[i] = PC_W'(32'h10C + 4 * i);
      for (int i = 0; i < 7; i += 2) begin
         n_checks++; if (out1_pc !== exp_pc[i]) begin n_fail++; $display("[TB] FAIL wrap_out1_%0d: got %0h expected %0h", i, out1_pc, exp_pc[i]); end
         if (i + 1 < 7) begin
            n_checks++; if (out2_pc !== exp_pc[i+1]) begin n_fail++; $display("[TB] FAIL wrap_out2_%0d: got %0h expected %0h", i, out2_pc, exp_pc[i+1]); end
         end
         set_launch(1'b1, 1'b1);
         advance();
      end
      idle();
      n_checks++; if (count !== CNT_W'(0) || sendout_flag1 !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_empty: got count %0d flag1 %b expected 0 0", count, sendout_flag1); end
   endtask

   task automatic test_stop_flush();
      reset_quiet();
      set_in(1'b1, 32'h200, 1'b1, 32'h204);
      advance();
      set_in(1'b1, 32'h208, 1'b0, 32'h0);
      advance();
      set_in(1'b0, '0, 1'b0, '0);
      stop = 1'b1;
      set_launch(1'b1, 1'b1);
      advance();
      n_checks++; if (count !== CNT_W'(3)) begin n_fail++; $display("[TB] FAIL stop_count: got %0d expected 3", count); end
      n_checks++; if (out1_pc !== 32'h200 || out2_pc !== 32'h204) begin n_fail++; $display("[TB] FAIL stop_pcs: got %0h/%0h expected 200/204", out1_pc, out2_pc); end
      set_in(1'b1, 32'h20C, 1'b1, 32'h210);
      advance();
      n_checks++; if (count !== CNT_W'(5) || out1_pc !== 32'h200) begin n_fail++; $display("[TB] FAIL stop_enqueue: got count %0d pc %0h expected 5 200", count, out1_pc); end
      stop = 1'b0;
      flush = 1'b1;
      set_in(1'b1, 32'h214, 1'b1, 32'h218);
      advance();
      idle();
      n_checks++; if (count !== CNT_W'(0) || sendout_flag1 !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_clear: got count %0d flag1 %b expected 0 0", count, sendout_flag1); end
      set_in(1'b0, '0, 1'b1, 32'h300);
      advance();
      set_in(1'b0, '0, 1'b0, '0);
      n_checks++; if (count !== CNT_W'(1) || out1_pc !== 32'h300 || out1_npc !== 32'h304) begin n_fail++; $display("[TB] FAIL compact: got count %0d pc %0h npc %0h expected 1 300 304", count, out1_pc, out1_npc); end
      n_checks++; if (sendout_flag2 !== 1'b0 || out2_pc !== '0) begin n_fail++; $display("[TB] FAIL compact_lane2: got flag2 %b pc %0h expected 0 0", sendout_flag2, out2_pc); end
   endtask

   task automatic test_overflow_partial();
      reset_quiet();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, PC_W'(32'h300 + 8 * i), 1'b1, PC_W'(32'h304 + 8 * i));
         advance();
      end
      set_in(1'b1, 32'h318, 1'b0, '0);
      advance();
      set_in(1'b1, 32'h400, 1'b1, 32'h404);
      advance();
      set_in(1'b0, '0, 1'b0, '0);
      n_checks++; if (count !== CNT_W'(8) || overflow_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_set: got count %0d ovf %b expected 8 1", count, overflow_err); end
      set_launch(1'b0, 1'b1);
      advance();
      n_checks++; if (count !== CNT_W'(8) || out1_pc !== 32'h300) begin n_fail++; $display("[TB] FAIL launch2_only: got count %0d pc %0h expected 8 300", count, out1_pc); end
      set_launch(1'b1, 1'b1);
      repeat (3) advance();
      idle();
      n_checks++; if (count !== CNT_W'(2) || out1_pc !== 32'h318 || out2_pc !== 32'h400) begin n_fail++; $display("[TB] FAIL ovf_keep_older: got count %0d pcs %0h/%0h expected 2 318/400", count, out1_pc, out2_pc); end
      n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow_err); end
      flush = 1'b1;
      advance();
      flush = 1'b0;
      n_checks++; if (overflow_err !== 1'b1 || count !== CNT_W'(0)) begin n_fail++; $display("[TB] FAIL ovf_after_flush: got ovf %b count %0d expected 1 0", overflow_err, count); end
      set_in(1'b1, 32'h500, 1'b1, 32'h504);
      advance();
      set_in(1'b0, '0, 1'b0, '0);
      rst = 1'b0;
      #2;
      n_checks++; if (overflow_err !== 1'b0 || count !== CNT_W'(0) || sendout_flag1 !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset: got ovf %b count %0d flag1 %b expected 0 0 0", overflow_err, count, sendout_flag1); end
      q.delete();
      model_ovf = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_random();
      bit guard;
      entry_t e0, e1;
      logic [CNT_W-1:0] exp_cnt;
      reset_quiet();
      for (int c = 0; c < 600; c++) begin
         flush = ($urandom_range(0, 99) < 3);
         stop  = ($urandom_range(0, 99) < 20);
         launch_flag1 = 1'($urandom_range(0, 1));
         launch_flag2 = 1'($urandom_range(0, 1));
         guard = ($urandom_range(0, 9) != 0) && ((DEPTH - q.size()) < 2);
         receive_flag1 = !guard && ($urandom_range(0, 3) != 0);
         receive_flag2 = !guard && ($urandom_range(0, 2) != 0);
         in1_inst = $urandom; in1_pc = $urandom; in1_npc = $urandom;
         in2_inst = $urandom; in2_pc = $urandom; in2_npc = $urandom;
         advance();
         exp_cnt = CNT_W'(q.size());
         e0 = '{default: '0};
         e1 = '{default: '0};
         if (q.size() >= 1) e0 = q[0];
         if (q.size() >= 2) e1 = q[1];
         n_checks++; if (count !== exp_cnt) begin n_fail++; $display("[TB] FAIL rnd_count c%0d: got %0d expected %0d", c, count, exp_cnt); end
         n_checks++; if (sendout_flag1 !== (q.size() >= 1) || sendout_flag2 !== (q.size() >= 2)) begin n_fail++; $display("[TB] FAIL rnd_flags c%0d: got %b%b size %0d", c, sendout_flag1, sendout_flag2, q.size()); end
         n_checks++; if (instbuf_full !== ((DEPTH - q.size()) < 2)) begin n_fail++; $display("[TB] FAIL rnd_full c%0d: got %b size %0d", c, instbuf_full, q.size()); end
         n_checks++; if (overflow_err !== model_ovf) begin n_fail++; $display("[TB] FAIL rnd_ovf c%0d: got %b expected %b", c, overflow_err, model_ovf); end
         n_checks++; if ({out1_inst, out1_pc, out1_npc} !== {e0.inst, e0.pc, e0.npc}) begin n_fail++; $display("[TB] FAIL rnd_out1 c%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", c, out1_inst, out1_pc, out1_npc, e0.inst, e0.pc, e0.npc); end
         n_checks++; if ({out2_inst, out2_pc, out2_npc} !== {e1.inst, e1.pc, e1.npc}) begin n_fail++; $display("[TB] FAIL rnd_out2 c%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", c, out2_inst, out2_pc, out2_npc, e1.inst, e1.pc, e1.npc); end
      end
      idle();
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      test_reset();
      test_push_pairs();
      test_pop_while_push();
      test_fill_wrap();
      test_stop_flush();
      test_overflow_partial();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
